// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the execute-stage ALU control unit:
// control codes, the NOP code and the multiply/divide sequencer states.
package alu_ctrl_pkg;

    localparam int CTRL_ADD    = 0;
    localparam int CTRL_SUB    = 1;
    localparam int CTRL_AND    = 2;
    localparam int CTRL_OR     = 3;
    localparam int CTRL_XOR    = 4;
    localparam int CTRL_SLT    = 5;
    localparam int CTRL_SLL    = 6;
    localparam int CTRL_SRL    = 7;
    localparam int CTRL_SRA    = 8;
    localparam int CTRL_SLTU   = 9;
    localparam int CTRL_MUL    = 16;
    localparam int CTRL_MULH   = 17;
    localparam int CTRL_MULHSU = 18;
    localparam int CTRL_MULHU  = 19;
    localparam int CTRL_DIV    = 20;
    localparam int CTRL_DIVU   = 21;
    localparam int CTRL_REM    = 22;
    localparam int CTRL_REMU   = 23;

    // -1 truncated to any control width yields the all-ones NOP code.
    localparam int CTRL_NOP    = -1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } md_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational ALU operation decode for RV32I with optional RV32M;
// flags multiply/divide ops and undecodable encodings.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W = 5,
    parameter bit EN_M   = 1'b1
) (
    input  logic              opcode_5,
    input  logic [1:0]        alu_op,
    input  logic              funct7_5,
    input  logic              funct7_0,
    input  logic [2:0]        funct3,
    output logic [CTRL_W-1:0] ctrl,
    output logic              is_m,
    output logic              is_div,
    output logic              illegal
);

    // Illegal R-type encodings are caught before any decode so they always map to NOP.
    always_comb begin
        ctrl    = CTRL_W'(CTRL_NOP);
        is_m    = 1'b0;
        is_div  = 1'b0;
        illegal = 1'b0;
        case (alu_op)
            2'b00: ctrl = CTRL_W'(CTRL_ADD);
            2'b01: ctrl = CTRL_W'(CTRL_SUB);
            2'b10: begin
                if (opcode_5 && ((funct7_5 && funct3 != 3'b000 && funct3 != 3'b101) ||
                                 (funct7_0 && (EN_M == 1'b0)) ||
                                 (funct7_0 && funct7_5))) begin
                    illegal = 1'b1;
                end else if (opcode_5 && funct7_0 && (EN_M == 1'b1)) begin
                    ctrl   = CTRL_W'(CTRL_MUL) | CTRL_W'(funct3);
                    is_m   = 1'b1;
                    is_div = funct3[2];
                end else begin
                    case (funct3)
                        3'b000: ctrl = (opcode_5 && funct7_5) ? CTRL_W'(CTRL_SUB) : CTRL_W'(CTRL_ADD);
                        3'b001: ctrl = CTRL_W'(CTRL_SLL);
                        3'b010: ctrl = CTRL_W'(CTRL_SLT);
                        3'b011: ctrl = CTRL_W'(CTRL_SLTU);
                        3'b100: ctrl = CTRL_W'(CTRL_XOR);
                        3'b101: ctrl = funct7_5 ? CTRL_W'(CTRL_SRA) : CTRL_W'(CTRL_SRL);
                        3'b110: ctrl = CTRL_W'(CTRL_OR);
                        default: ctrl = CTRL_W'(CTRL_AND);
                    endcase
                end
            end
            default: ctrl = CTRL_W'(CTRL_NOP);
        endcase
    end

endmodule

// File: rtl/alu_control_seq.sv
// Execute-stage ALU control: combinational decode plus a sequencer that starts the
// iterative multiply/divide unit and stalls the pipeline for a fixed latency.
module alu_control_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W     = 5,
    parameter bit EN_M       = 1'b1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Valid,
    input  logic              i_Flush,
    input  logic              i_OpCode_5,
    input  logic [1:0]        i_AluOp,
    input  logic              i_Function7_5,
    input  logic              i_Function7_0,
    input  logic [2:0]        i_Function3,
    output logic [CTRL_W-1:0] o_AluControl,
    output logic              o_MdStart,
    output logic              o_Stall,
    output logic              o_Done,
    output logic              o_Illegal
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_is_m;
    logic              dec_is_div;
    logic              dec_illegal;

    md_state_e         state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [CTRL_W-1:0] code_q, code_next;

    alu_op_decode #(
        .CTRL_W (CTRL_W),
        .EN_M   (EN_M)
    ) u_decode (
        .opcode_5 (i_OpCode_5),
        .alu_op   (i_AluOp),
        .funct7_5 (i_Function7_5),
        .funct7_0 (i_Function7_0),
        .funct3   (i_Function3),
        .ctrl     (dec_ctrl),
        .is_m     (dec_is_m),
        .is_div   (dec_is_div),
        .illegal  (dec_illegal)
    );

    assign o_Illegal = i_Valid & dec_illegal;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            code_q <= CTRL_W'(CTRL_NOP);
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            code_q <= code_next;
        end
    end

    // The counter is loaded with latency-1 so BUSY lasts exactly N cycles before DONE.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        code_next    = code_q;
        o_AluControl = dec_ctrl;
        o_MdStart    = 1'b0;
        o_Stall      = 1'b0;
        o_Done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_Valid && dec_is_m && !i_Flush) begin
                    o_MdStart  = 1'b1;
                    o_Stall    = 1'b1;
                    code_next  = dec_ctrl;
                    cnt_next   = dec_is_div ? DIV_LOAD : MUL_LOAD;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                o_AluControl = code_q;
                o_Stall      = 1'b1;
                if (cnt == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                o_AluControl = code_q;
                o_Done       = 1'b1;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (i_Flush) begin
            o_MdStart  = 1'b0;
            o_Stall    = 1'b0;
            o_Done     = 1'b0;
            state_next = ST_IDLE;
        end
    end

endmodule
